reg_read_stage: RTL and testbench

- Operand-fetch stage: reader side of the architectural register file that the writeback stage writes.
- Accepts decoded instructions and reads rs1/rs2 from the 32-entry regfile array, bypassing the writeback port in the same cycle.
- Tracks outstanding writers per register in a scoreboard and stalls readers until their operands are committed.
- Sits between decode and execute; drives a registered valid/ready output to execute.

---
 rtl/reg_read_stage_pkg.sv | 21 ++
 rtl/reg_read_stage_scoreboard.sv | 62 ++++++
 rtl/reg_read_stage.sv | 149 ++++++++++++++
 tb/tb_reg_read_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_read_stage_pkg.sv
// reg_read_stage_pkg: shared types and constants for the operand-fetch stage.
//   Addr / Inst / IId  : PC, raw instruction and instruction-id types
//   UInt5 / UIntX      : register address and register value types
//   PendCnt            : per-register pending-writer counter
//   IID_X              : "no instruction" id placed in the output slot at reset
package reg_read_stage_pkg;

  localparam int XLEN     = 32;
  localparam int PEND_W   = 2;
  localparam int NUM_REGS = 32;

  typedef logic [31:0]       Addr;
  typedef logic [31:0]       Inst;
  typedef logic [7:0]        IId;
  typedef logic [4:0]        UInt5;
  typedef logic [XLEN-1:0]   UIntX;
  typedef logic [PEND_W-1:0] PendCnt;

  localparam IId IID_X = 8'hFF;

endpackage

// File: rtl/reg_read_stage_scoreboard.sv
// reg_scoreboard: per-register count of issued-but-not-written-back writers.
//   clk, rst_n        : clock, async active-low reset
//   flush             : clears every counter (a same-cycle decrement is dropped)
//   inc_i, inc_addr_i : one more writer issued to inc_addr_i
//   dec_i, dec_addr_i : one writer to dec_addr_i retired
//   busy_o[r]         : register r still has writers once this cycle's retire is applied
//   sat_o[r]          : register r cannot take another writer this cycle
module reg_scoreboard
  import reg_read_stage_pkg::*;
#(
  parameter int PEND_W = reg_read_stage_pkg::PEND_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                inc_i,
  input  logic [4:0]          inc_addr_i,
  input  logic                dec_i,
  input  logic [4:0]          dec_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [NUM_REGS-1:0] sat_o
);

  localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];

  // Status vectors and next counter values for every register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc_r;
      logic dec_r;
      inc_r = inc_i && (inc_addr_i == 5'(r));
      dec_r = dec_i && (dec_addr_i == 5'(r));
      // A retire with nothing pending leaves the count at zero, so never busy.
      busy_o[r] = dec_r ? (pend_q[r] > CNT_ONE) : (pend_q[r] != CNT_ZERO);
      sat_o[r]  = (pend_q[r] == CNT_MAX) && !dec_r;
      if (r == 0 || flush) begin
        pend_d[r] = CNT_ZERO;
      end else if (inc_r && !dec_r) begin
        pend_d[r] = (pend_q[r] == CNT_MAX) ? pend_q[r] : pend_q[r] + CNT_ONE;
      end else if (dec_r && !inc_r) begin
        pend_d[r] = (pend_q[r] == CNT_ZERO) ? pend_q[r] : pend_q[r] - CNT_ONE;
      end else begin
        pend_d[r] = pend_q[r];
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= CNT_ZERO;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: operand-fetch stage between decode and execute.
//   in_*          : decoded instruction with valid/ready handshake
//   regfile, wb_* : architectural registers and the writeback port (bypassed)
//   out_*         : registered instruction + operands with valid/ready to execute
//   flush         : kills the output slot and clears the scoreboard
//   stall_count   : cycles an instruction waited (in_valid & !in_ready, not flushing)
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int XLEN   = reg_read_stage_pkg::XLEN,
  parameter int PEND_W = reg_read_stage_pkg::PEND_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  Addr             in_pc,
  input  Inst             in_inst,
  input  IId              in_inst_id,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rf_wen,
  input  logic [XLEN-1:0] regfile [NUM_REGS],
  input  logic            wb_valid,
  input  logic            wb_rf_wen,
  input  logic [4:0]      wb_reg_addr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output Addr             out_pc,
  output Inst             out_inst,
  output IId              out_inst_id,
  output logic [4:0]      out_rd,
  output logic            out_rf_wen,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [63:0]     stall_count
);

  logic                wb_hit_s;
  logic                accept_s;
  logic                blocked_s;
  logic [XLEN-1:0]     rs1_data_s;
  logic [XLEN-1:0]     rs2_data_s;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] sat_s;

  logic            out_valid_q;
  Addr             out_pc_q;
  Inst             out_inst_q;
  IId              out_inst_id_q;
  logic [4:0]      out_rd_q;
  logic            out_rf_wen_q;
  logic [XLEN-1:0] out_rs1_q;
  logic [XLEN-1:0] out_rs2_q;
  logic [63:0]     stall_q;

  // x0 reads as zero; a same-cycle writeback to the register wins over the array.
  function automatic logic [XLEN-1:0] read_operand(input logic [4:0] addr);
    if (addr == 5'd0) begin
      return {XLEN{1'b0}};
    end else if (wb_hit_s && (wb_reg_addr == addr)) begin
      return wb_wdata;
    end else begin
      return regfile[addr];
    end
  endfunction

  // Hazard detection and handshake.
  always_comb begin
    wb_hit_s   = wb_valid && wb_rf_wen && (wb_reg_addr != 5'd0);
    rs1_data_s = read_operand(in_rs1);
    rs2_data_s = read_operand(in_rs2);
    // busy_s/sat_s already account for this cycle's writeback, so a
    // retiring writer releases its readers in the same cycle.
    blocked_s  = (in_use_rs1 && (in_rs1 != 5'd0) && busy_s[in_rs1]) ||
                 (in_use_rs2 && (in_rs2 != 5'd0) && busy_s[in_rs2]) ||
                 (in_rf_wen  && (in_rd  != 5'd0) && sat_s[in_rd]);
    in_ready   = (!out_valid_q || out_ready) && !blocked_s && !flush;
    accept_s   = in_valid && in_ready;
  end

  reg_scoreboard #(.PEND_W(PEND_W)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .inc_i      (accept_s && in_rf_wen),
    .inc_addr_i (in_rd),
    .dec_i      (wb_hit_s),
    .dec_addr_i (wb_reg_addr),
    .busy_o     (busy_s),
    .sat_o      (sat_s)
  );

  // Output slot: load on accept, empty on drain or flush, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'd0;
      out_inst_q    <= 32'd0;
      out_inst_id_q <= IID_X;
      out_rd_q      <= 5'd0;
      out_rf_wen_q  <= 1'b0;
      out_rs1_q     <= {XLEN{1'b0}};
      out_rs2_q     <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept_s) begin
      out_valid_q   <= 1'b1;
      out_pc_q      <= in_pc;
      out_inst_q    <= in_inst;
      out_inst_id_q <= in_inst_id;
      out_rd_q      <= in_rd;
      out_rf_wen_q  <= in_rf_wen;
      out_rs1_q     <= rs1_data_s;
      out_rs2_q     <= rs2_data_s;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Stall cycle counter (free-running wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 64'd0;
    end else if (in_valid && !in_ready && !flush) begin
      stall_q <= stall_q + 64'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_inst     = out_inst_q;
  assign out_inst_id  = out_inst_id_q;
  assign out_rd       = out_rd_q;
  assign out_rf_wen   = out_rf_wen_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios followed by random traffic,
// all checked every cycle against a pending-writer-count reference model.
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;

  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [7:0]  in_inst_id;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rf_wen;
  logic [31:0] rf [NUM_REGS];
  logic        wb_valid, wb_rf_wen;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_wdata;
  logic        out_valid, out_ready, out_rf_wen;
  logic [31:0] out_pc, out_inst, out_rs1_data, out_rs2_data;
  logic [7:0]  out_inst_id;
  logic [4:0]  out_rd;
  logic [63:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int              m_pend [32];
  bit              m_ov;
  logic [31:0]     m_pc, m_inst, m_rs1d, m_rs2d;
  logic [7:0]      m_iid;
  logic [4:0]      m_rd;
  bit              m_wen;
  longint unsigned m_stall;
  bit              m_ready;

  reg_read_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_inst_id(in_inst_id), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd),
    .in_rf_wen(in_rf_wen), .regfile(rf), .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen),
    .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_inst_id(out_inst_id), .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wb_hits(input int r);
    return wb_valid && wb_rf_wen && (wb_reg_addr != 5'd0) && (int'(wb_reg_addr) == r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_hits(int'(a))) return wb_wdata;
    return rf[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_ov = 0; m_pc = 32'd0; m_inst = 32'd0; m_iid = IID_X; m_rd = 5'd0;
    m_wen = 0; m_rs1d = 32'd0; m_rs2d = 32'd0; m_stall = 0;
  endtask

  // Who may issue now, from outstanding-writer counts.
  task automatic model_comb();
    bit blk;
    blk = 0;
    if (in_use_rs1 && in_rs1 != 5'd0 && (m_pend[in_rs1] - (wb_hits(int'(in_rs1)) ? 1 : 0)) > 0) blk = 1;
    if (in_use_rs2 && in_rs2 != 5'd0 && (m_pend[in_rs2] - (wb_hits(int'(in_rs2)) ? 1 : 0)) > 0) blk = 1;
    if (in_rf_wen && in_rd != 5'd0 && m_pend[in_rd] == MAXP && !wb_hits(int'(in_rd))) blk = 1;
    m_ready = (!m_ov || out_ready) && !blk && !flush;
  endtask

  task automatic model_edge();
    bit acc;
    acc = in_valid && m_ready;
    if (in_valid && !m_ready && !flush) m_stall++;
    if (flush) begin
      m_ov = 0;
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (wb_valid && wb_rf_wen && wb_reg_addr != 5'd0 && m_pend[wb_reg_addr] > 0)
        m_pend[wb_reg_addr]--;
      if (acc) begin
        m_ov = 1; m_pc = in_pc; m_inst = in_inst; m_iid = in_inst_id; m_rd = in_rd;
        m_wen = in_rf_wen; m_rs1d = operand(in_rs1); m_rs2d = operand(in_rs2);
        if (in_rf_wen && in_rd != 5'd0) m_pend[in_rd]++;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("stall_count", stall_count, m_stall);
    if (m_ov) begin
      check("out_pc", out_pc, m_pc);
      check("out_inst", out_inst, m_inst);
      check("out_inst_id", out_inst_id, m_iid);
      check("out_rd", out_rd, m_rd);
      check("out_rf_wen", out_rf_wen, m_wen);
      check("out_rs1_data", out_rs1_data, m_rs1d);
      check("out_rs2_data", out_rs2_data, m_rs2d);
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    #1;
    model_comb();
    check("in_ready", in_ready, m_ready);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_inst(input bit v, input logic [4:0] rs1, input bit u1,
                          input logic [4:0] rs2, input bit u2,
                          input logic [4:0] rd, input bit wen);
    in_valid = v; in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rf_wen = wen;
    in_pc = $urandom; in_inst = $urandom; in_inst_id = 8'($urandom_range(0, 254));
  endtask

  task automatic set_wb(input bit v, input logic [4:0] addr, input logic [31:0] data);
    wb_valid = v; wb_rf_wen = v; wb_reg_addr = addr; wb_wdata = data;
  endtask

  initial begin
    longint unsigned s0;
    logic [31:0] held_pc;
    int cand [$];

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    set_wb(0, 5'd0, 32'd0);
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_inst_id", out_inst_id, IID_X);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_out_rs1", out_rs1_data, 32'd0);
    check("rst_stall", stall_count, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // independent ADDIs to x5 and x6 issue back to back
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd5, 1); cycle();
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd6, 1); cycle();

    // RAW on x5: stalls two cycles, then issues on the writeback via bypass
    s0 = m_stall;
    set_inst(1, 5'd5, 1, 5'd0, 0, 5'd9, 0); cycle(); cycle();
    set_wb(1, 5'd5, 32'hDEADBEEF); cycle();
    check("raw_bypass", out_rs1_data, 32'hDEADBEEF);
    check("raw_stalls", stall_count, s0 + 2);
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    set_wb(1, 5'd6, $urandom); cycle();
    set_wb(0, 5'd0, 32'd0);

    // backpressure: slot full for three cycles, then next loads
    out_ready = 1'b0;
    set_inst(1, 5'd1, 1, 5'd2, 1, 5'd0, 0); cycle();
    held_pc = in_pc;
    set_inst(1, 5'd3, 1, 5'd4, 1, 5'd0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("bp_hold_pc", out_pc, held_pc);
    out_ready = 1'b1; cycle();
    check("bp_load_pc", out_pc, in_pc);
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); cycle();

    // saturation of x7
    for (int i = 0; i < 3; i++) begin set_inst(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); cycle(); end
    set_inst(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); cycle();
    #1 check("sat_blocked", in_ready, 1'b0);
    set_wb(1, 5'd7, $urandom); cycle();
    set_wb(0, 5'd0, 32'd0);
    #1 check("sat_still_full", in_ready, 1'b0);
    cycle();
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin set_wb(1, 5'd7, $urandom); cycle(); end
    set_wb(0, 5'd0, 32'd0);

    // flush with a simultaneous writeback to x3, then reader of x3 issues
    for (int i = 0; i < 2; i++) begin set_inst(1, 5'd0, 0, 5'd0, 0, 5'd3, 1); cycle(); end
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    flush = 1'b1; set_wb(1, 5'd3, 32'h12345678); cycle();
    flush = 1'b0; set_wb(0, 5'd0, 32'd0);
    rf[3] = 32'hCAFE0003;
    set_inst(1, 5'd3, 1, 5'd0, 0, 5'd0, 0); cycle();
    check("flush_reader", out_rs1_data, 32'hCAFE0003);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      set_inst($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 4) < 2) begin
        set_wb(1, 5'(cand[$urandom_range(0, cand.size() - 1)]), $urandom);
      end else begin
        // non-hitting writeback traffic
        wb_valid = $urandom_range(0, 1) == 1; wb_rf_wen = 1'b0;
        wb_reg_addr = 5'($urandom_range(0, 31)); wb_wdata = $urandom;
        if ($urandom_range(0, 3) == 0) begin wb_rf_wen = 1'b1; wb_reg_addr = 5'd0; end
      end
      cycle();
    end

    // async reset while the output slot is occupied
    flush = 1'b0; set_wb(0, 5'd0, 32'd0); out_ready = 1'b1;
    set_inst(0, 5'd0, 0, 5'd0, 0, 5'd0, 0); cycle();
    out_ready = 1'b0;
    set_inst(1, 5'd0, 0, 5'd0, 0, 5'd0, 0); cycle();
    check("pre_reset_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_stall", stall_count, 64'd0);
    check("async_rst_iid", out_inst_id, IID_X);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
